bit_deserializer: RTL and testbench

- Serial-to-parallel stage that sits directly downstream of the single-bit registered flop stage.
- Collects qualified serial bits into WIDTH-bit words and presents them on a parallel bus with a valid/ready handshake.
- Holds completed words in a small output buffer so the consumer can stall without losing data.
- Tracks framing with an optional start-of-frame marker and flags dropped words with a sticky overflow bit.

---
 rtl/bit_deserializer_pkg.sv | 20 ++
 rtl/bit_deserializer_fifo.sv | 49 ++++
 rtl/bit_deserializer.sv | 98 +++++++++
 tb/tb_bit_deserializer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_deserializer_pkg.sv
// Shared definitions for the bit deserializer: default sizes, FSM encoding
// and a constant-foldable ceil(log2) helper for port and pointer widths.
package bit_deserializer_pkg;

   localparam int DESER_WIDTH_DEF = 8;
   localparam int DESER_DEPTH_DEF = 2;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } deser_state_t;

   function automatic int clog2_f(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/bit_deserializer_fifo.sv
// Completed-word buffer: DEPTH-entry synchronous FIFO whose pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module deser_fifo
   import bit_deserializer_pkg::*;
#(
   parameter int WIDTH = DESER_WIDTH_DEF,
   parameter int DEPTH = DESER_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2_f(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the head slot, so a push into a full buffer still lands.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel stage: assembles qualified bits into WIDTH-bit words,
// buffers completed words and hands them out over a valid/ready bus.
module bit_deserializer
   import bit_deserializer_pkg::*;
#(
   parameter int WIDTH     = DESER_WIDTH_DEF,
   parameter bit MSB_FIRST = 1'b1,
   parameter int DEPTH     = DESER_DEPTH_DEF
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            d,
   input  logic                            d_valid,
   input  logic                            sof,
   output logic [WIDTH-1:0]                bus,
   output logic                            bus_valid,
   input  logic                            bus_ready,
   output logic [clog2_f(WIDTH+1)-1:0]     bit_count,
   output logic                            overflow
);

   localparam int CW = clog2_f(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   deser_state_t     state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] fresh;
   logic [CW-1:0]    cnt;
   logic             word_done;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_dout;
   logic [WIDTH-1:0] last_word;

   // shifted: current bit appended to the partial word; fresh: current bit starting a new word
   always_comb begin
      if (MSB_FIRST) begin
         shifted = {shreg[WIDTH-2:0], d};
         fresh   = {{(WIDTH-1){1'b0}}, d};
      end else begin
         shifted = {d, shreg[WIDTH-1:1]};
         fresh   = {d, {(WIDTH-1){1'b0}}};
      end
   end

   assign word_done = d_valid && !sof && (state == COLLECT) && (cnt == LAST_BIT);
   assign bus_valid = !fifo_empty;
   assign pop       = bus_valid && bus_ready;
   assign bus       = bus_valid ? fifo_dout : last_word;
   assign bit_count = cnt;

   deser_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (word_done),
      .din   (shifted),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         last_word <= '0;
      end else begin
         if (pop) last_word <= fifo_dout;
         if (word_done && fifo_full && !pop) overflow <= 1'b1;
         if (d_valid) begin
            // sof drops any partial word; the current bit opens the new one
            if (sof) begin
               shreg <= fresh;
               cnt   <= CNT_ONE;
               state <= COLLECT;
            end else if (word_done) begin
               shreg <= '0;
               cnt   <= '0;
               state <= IDLE;
            end else begin
               shreg <= shifted;
               cnt   <= cnt + CNT_ONE;
               state <= COLLECT;
            end
         end
      end
   end

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: MSB-first and LSB-first instances share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_bit_deserializer;

   localparam int W = 8;
   localparam int D = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstb, d, d_valid, sof, bus_ready;
   logic [W-1:0] bus_m, bus_l;
   logic         bv_m, bv_l, ov_m, ov_l;
   logic [3:0]   bc_m, bc_l;

   bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .DEPTH(D)) dut_msb (
      .clk(clk), .rstb(rstb), .d(d), .d_valid(d_valid), .sof(sof),
      .bus(bus_m), .bus_valid(bv_m), .bus_ready(bus_ready),
      .bit_count(bc_m), .overflow(ov_m));

   bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .DEPTH(D)) dut_lsb (
      .clk(clk), .rstb(rstb), .d(d), .d_valid(d_valid), .sof(sof),
      .bus(bus_l), .bus_valid(bv_l), .bus_ready(bus_ready),
      .bit_count(bc_l), .overflow(ov_l));

   int checks = 0;
   int errors = 0;

   // Model: received bits of the partial word, completed words (first bit in
   // bit W-1), last popped word, sticky overflow.
   logic         bits_q[$];
   logic [W-1:0] wq[$];
   logic [W-1:0] last_w;
   logic         ovf;
   logic [W-1:0] m_w;
   logic         chk_en;
   logic         exp_bv;
   logic [W-1:0] exp_bus;

   function automatic logic [W-1:0] rev(input logic [W-1:0] x);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = x[W-1-i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      bits_q.delete();
      wq.delete();
      last_w = '0;
      ovf    = 1'b0;
   endtask

   always @(posedge clk) begin
      if (rstb) begin
         if (wq.size() > 0 && bus_ready) last_w = wq.pop_front();
         if (d_valid) begin
            if (sof) bits_q.delete();
            bits_q.push_back(d);
            if (bits_q.size() == W) begin
               for (int i = 0; i < W; i++) m_w[W-1-i] = bits_q[i];
               if (wq.size() < D) wq.push_back(m_w);
               else ovf = 1'b1;
               bits_q.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && rstb) begin
         exp_bv  = (wq.size() > 0);
         exp_bus = exp_bv ? wq[0] : last_w;
         check("bus_valid_msb", 32'(bv_m), 32'(exp_bv));
         check("bus_valid_lsb", 32'(bv_l), 32'(exp_bv));
         check("bus_msb", 32'(bus_m), 32'(exp_bus));
         check("bus_lsb", 32'(bus_l), 32'(rev(exp_bus)));
         check("bit_count_msb", 32'(bc_m), 32'(bits_q.size()));
         check("bit_count_lsb", 32'(bc_l), 32'(bits_q.size()));
         check("overflow_msb", 32'(ov_m), 32'(ovf));
         check("overflow_lsb", 32'(ov_l), 32'(ovf));
      end
   end

   task automatic cyc(input logic dv, input logic dd, input logic s, input logic rdy);
      @(negedge clk);
      d_valid   = dv;
      d         = dd;
      sof       = s;
      bus_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // w is given with the first transmitted bit in bit W-1
   task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic last_rdy);
      for (int i = 0; i < W; i++) cyc(1'b1, w[W-1-i], 1'b0, (i == W-1) ? last_rdy : rdy);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_bus"}, 32'(bus_m), 32'h0);
      check({tag, "_bus_valid"}, 32'(bv_m), 32'h0);
      check({tag, "_bit_count"}, 32'(bc_m), 32'h0);
      check({tag, "_overflow"}, 32'(ov_m), 32'h0);
      check({tag, "_overflow_lsb"}, 32'(ov_l), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      d_valid = 1'b0;
      sof     = 1'b0;
      #2;
      rstb   = 1'b0;
      chk_en = 1'b0;
      model_reset();
      #1;
      check_cleared("async_reset");
      @(negedge clk);
      rstb   = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      rstb = 1'b0; d = 1'b0; d_valid = 1'b0; sof = 1'b0; bus_ready = 1'b0;
      chk_en = 1'b0;
      model_reset();

      // bits arriving during reset are ignored
      repeat (2) @(negedge clk);
      d_valid = 1'b1; d = 1'b1;
      repeat (3) @(negedge clk);
      d_valid = 1'b0;
      check_cleared("in_reset");
      rstb   = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      check_cleared("after_release");

      // reset with a buffered word and a partial word in flight
      send_word(8'h5A, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check("midword_bus", 32'(bus_m), 32'h5A);
      check("midword_bit_count", 32'(bc_m), 32'd3);
      do_reset();

      // A5, MSB first, valid exactly one cycle
      send_word(8'hA5, 1'b1, 1'b1);
      check("a5_valid", 32'(bv_m), 32'h1);
      check("a5_bus", 32'(bus_m), 32'hA5);
      check("a5_bus_lsb", 32'(bus_l), 32'hA5);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("a5_valid_gone", 32'(bv_m), 32'h0);
      check("a5_bus_held", 32'(bus_m), 32'hA5);

      // bit order: 1,1,0,0,0,0,0,0
      send_word(8'hC0, 1'b1, 1'b1);
      check("order_msb", 32'(bus_m), 32'hC0);
      check("order_lsb", 32'(bus_l), 32'h03);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // backpressure and overflow
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      check("bp_no_ovf_yet", 32'(ov_m), 32'h0);
      send_word(8'h33, 1'b0, 1'b0);
      check("bp_overflow", 32'(ov_m), 32'h1);
      check("bp_overflow_lsb", 32'(ov_l), 32'h1);
      check("bp_head", 32'(bus_m), 32'h11);
      check("bp_head_lsb", 32'(bus_l), 32'h88);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("bp_second", 32'(bus_m), 32'h22);
      check("bp_second_lsb", 32'(bus_l), 32'h44);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("bp_drained", 32'(bv_m), 32'h0);
      check("bp_sticky", 32'(ov_m), 32'h1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("bp_sticky_later", 32'(ov_m), 32'h1);
      do_reset();

      // full buffer with simultaneous pop on the completing cycle
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 1'b1);
      check("fp_no_overflow", 32'(ov_m), 32'h0);
      check("fp_head", 32'(bus_m), 32'h22);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("fp_third", 32'(bus_m), 32'h33);
      check("fp_third_lsb", 32'(bus_l), 32'hCC);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("fp_drained", 32'(bv_m), 32'h0);
      check("fp_still_no_ovf", 32'(ov_m), 32'h0);

      // reframe: three bits, then sof on the fourth
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1);
      check("rf_count3", 32'(bc_m), 32'd3);
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      check("rf_count1", 32'(bc_m), 32'd1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      check("rf_sof_no_valid", 32'(bc_m), 32'd1);
      for (int i = 0; i < 7; i++) cyc(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1);
      check("rf_word", 32'(bus_m), 32'h55);
      check("rf_word_lsb", 32'(bus_l), 32'hAA);
      check("rf_valid", 32'(bv_m), 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("rf_single_word", 32'(bv_m), 32'h0);

      // mixed traffic exercising pointer wrap, stalls and reframes
      for (int i = 0; i < 200; i++)
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 23) == 0), 1'($urandom_range(0, 2) != 0));
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
